number_serializer: RTL
======================

# number_serializer

Streaming converter from a signed 64-bit integer tape entry to its JSON decimal text. It sits on the output (stringify) path, which runs in the opposite direction to the parser's number builder. It accepts one two's-complement tape value per transaction and converts the magnitude to BCD using an iterative double-dabble engine. It then emits the ASCII characters one byte per handshake, with an optional leading '-'. Floats are out of scope; every input is treated as a signed int64.

## Interface
Parameters:
- none (all widths are fixed by the tape format)

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- tapeEntry  input  64  two's-complement integer value to serialize.
- in_valid  input  1  tapeEntry is valid.
- in_ready  output  1  block is idle and can accept a value.
- out_char  output  8  ASCII character: '-' (0x2D) or '0'..'9' (0x30..0x39).
- out_valid  output  1  out_char is valid.
- out_ready  input  1  downstream accepts out_char.
- out_last  output  1  out_char is the final character of the number.
- busy  output  1  a conversion or emission is in progress.

## Operation
States: IDLE, CONVERT, EMIT_SIGN, EMIT_DIGITS.

- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch neg=tapeEntry[63] and mag = neg ? (~tapeEntry+1) : tapeEntry, as a 64-bit unsigned value.
  - For 0x8000_0000_0000_0000 this gives mag=2^63, which is correct.
  - Clear the 80-bit BCD register (20 digits) and the bit counter, then go to CONVERT.
- **CONVERT**
  - Each cycle: add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1.
  - After 64 iterations, set digit index di = position of the most significant nonzero nibble (di=0 when all nibbles are zero, so 0 prints as "0").
  - Then go to EMIT_SIGN if neg, else EMIT_DIGITS.
- **EMIT_SIGN**
  - Drive out_char=0x2D, out_valid=1, out_last=0.
  - On out_ready, go to EMIT_DIGITS.
- **EMIT_DIGITS**
  - Drive out_char=0x30+bcd[di], out_valid=1, out_last=(di==0).
  - On out_ready: if di==0 go to IDLE, else decrement di.
- **Output rules**
  - Digits are emitted most-significant first.
  - Leading zeros are never emitted.
  - At most 20 characters are emitted per number: '-' plus 19 digits.
- **Handshake rules**
  - A transfer occurs when out_valid&&out_ready on a rising edge.
  - While out_valid=1 and out_ready=0, out_char and out_last hold stable.
  - out_valid never drops without a transfer, except on rst.
  - in_ready=0 in every state other than IDLE; tapeEntry is ignored outside IDLE.
- **busy:** 1 in every state except IDLE.
- **Reset behaviour**
  - rst=1 in any state forces IDLE on the next edge.
  - A partially emitted number is abandoned: no out_last is produced and no further characters are sent.
  - Reset values: out_valid=0, out_last=0, out_char=8'h00, busy=0, in_ready=0 while rst is high and 1 the first cycle after rst deasserts, internal BCD/mag/counter all zero.

## Timing
- Input accepted at edge T: CONVERT occupies cycles T+1..T+64, and the first out_valid is at T+65 (T+33 with the macro enabled).
- Emission takes one character per cycle under continuous out_ready.
- The final transfer at edge E gives in_ready=1 at E+1.
- Back-to-back acceptance is therefore impossible; minimum throughput is 65+N cycles per number, where N is the character count.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid/out_char.

## Configuration
- `NUMBER_SERIALIZER_DABBLE2X_EN`
  - **Defined:** CONVERT performs two add-3/shift iterations per cycle (two cascaded correction stages) and completes in 32 cycles; first out_valid at T+33.
  - **Undefined:** one iteration per cycle, 64 cycles, first out_valid at T+65.
  - Character output is identical either way.

## Test plan
- tapeEntry=0 → single transfer 0x30 with out_last=1; out_valid first high exactly 65 cycles after acceptance (33 with the macro).
- tapeEntry=0xFFFF_FFFF_FFFF_FFFF → "-1": 0x2D (last=0), then 0x31 (last=1).
- tapeEntry=12345 with out_ready held 1 → 0x31,0x32,0x33,0x34,0x35 on consecutive cycles; out_last only on 0x35; in_ready=1 the cycle after.
- tapeEntry=0x8000_0000_0000_0000 → "-9223372036854775808" (20 chars).
- tapeEntry=0x7FFF_FFFF_FFFF_FFFF with out_ready randomly toggled → "9223372036854775807"; out_char stable during every stall; in_valid pulses during busy are ignored.
- tapeEntry=-42: assert rst for one cycle after the '-' transfer → no further out_valid; in_ready=1 after reset; next input 7 → "7" with out_last=1.

Source files
------------

// File: rtl/number_serializer_if.sv
// Handshake bundle for number_serializer: tape value input and character stream output.
// The master side feeds values and drains characters; the slave side is the serializer.
interface number_serializer_if;
  logic [63:0] tapeEntry;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  modport master (
    output tapeEntry, in_valid, out_ready,
    input  in_ready, out_char, out_valid, out_last, busy
  );

  modport slave (
    input  tapeEntry, in_valid, out_ready,
    output in_ready, out_char, out_valid, out_last, busy
  );
endinterface

// File: rtl/number_serializer.sv
// number_serializer: signed int64 tape entry -> JSON decimal ASCII, one character per handshake.
// Magnitude is converted to 20-digit BCD by an iterative double-dabble engine, then digits are
// streamed most-significant first with an optional leading '-'.
// Build option: NUMBER_SERIALIZER_DABBLE2X_EN runs two add-3/shift iterations per cycle
// (32 conversion cycles instead of 64); character output is identical either way.
//
// state       | meaning
// IDLE        | in_ready high, waiting for a tape value
// CONVERT     | double-dabble iterations on {bcd, mag}
// EMIT_SIGN   | presenting '-' for a negative value
// EMIT_DIGITS | presenting bcd[digitIdx], counting digitIdx down to 0
module number_serializer (
  input logic          clk,
  input logic          rst,
  number_serializer_if.slave ser
);

`ifdef NUMBER_SERIALIZER_DABBLE2X_EN
  localparam logic [6:0] ITER_STEP = 7'd2;
`else
  localparam logic [6:0] ITER_STEP = 7'd1;
`endif
  // bitCount value at the start of the cycle that performs the final iteration(s)
  localparam logic [6:0] LAST_COUNT = 7'd64 - ITER_STEP;

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT_SIGN, EMIT_DIGITS} serState;

  serState     state;
  logic        neg;
  logic [63:0] mag;
  logic [79:0] bcd;
  logic [6:0]  bitCount;
  logic [4:0]  digitIdx;
  logic [7:0]  outChar;
  logic        outValid;
  logic        outLast;
  logic        inReady;
  logic        busyReg;

  logic [143:0] stage1;
  logic [143:0] nextWork;
  logic [79:0]  nextBcd;
  logic [4:0]   nextTop;

  // One double-dabble iteration on {bcd, mag}: correct BCD nibbles >= 5, then shift left.
  function automatic logic [143:0] dabbleStep(input logic [143:0] v);
    logic [143:0] adj;
    adj = v;
    for (int i = 0; i < 20; i++) begin
      if (v[64 + i*4 +: 4] >= 4'd5) begin
        adj[64 + i*4 +: 4] = v[64 + i*4 +: 4] + 4'd3;
      end
    end
    return {adj[142:0], 1'b0};
  endfunction

  // Index of the most significant nonzero nibble; 0 for an all-zero register.
  function automatic logic [4:0] topNibble(input logic [79:0] b);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 20; i++) begin
      if (b[i*4 +: 4] != 4'd0) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  // ASCII character for BCD digit idx.
  function automatic logic [7:0] digitChar(input logic [79:0] b, input logic [4:0] idx);
    logic [79:0] shifted;
    shifted = b >> {idx, 2'b00};
    return 8'h30 + {4'h0, shifted[3:0]};
  endfunction

  // Next conversion step; the final step's result also feeds the first character directly,
  // so emission starts the cycle right after the last iteration.
  always_comb begin
    stage1 = dabbleStep({bcd, mag});
`ifdef NUMBER_SERIALIZER_DABBLE2X_EN
    nextWork = dabbleStep(stage1);
`else
    nextWork = stage1;
`endif
    nextBcd = nextWork[143:64];
    nextTop = topNibble(nextBcd);
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      neg      <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      bitCount <= '0;
      digitIdx <= '0;
      outChar  <= 8'h00;
      outValid <= 1'b0;
      outLast  <= 1'b0;
      inReady  <= 1'b0;
      busyReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          outValid <= 1'b0;
          outLast  <= 1'b0;
          busyReg  <= 1'b0;
          inReady  <= 1'b1;
          if (ser.in_valid && inReady) begin
            neg      <= ser.tapeEntry[63];
            // ~x+1 of 0x8000...0 is 2^63, which is the correct magnitude as unsigned
            mag      <= ser.tapeEntry[63] ? (~ser.tapeEntry + 64'd1) : ser.tapeEntry;
            bcd      <= '0;
            bitCount <= '0;
            inReady  <= 1'b0;
            busyReg  <= 1'b1;
            state    <= CONVERT;
          end
        end

        CONVERT: begin
          {bcd, mag} <= nextWork;
          bitCount   <= bitCount + ITER_STEP;
          if (bitCount == LAST_COUNT) begin
            digitIdx <= nextTop;
            outValid <= 1'b1;
            if (neg) begin
              outChar <= 8'h2D;
              outLast <= 1'b0;
              state   <= EMIT_SIGN;
            end else begin
              outChar <= digitChar(nextBcd, nextTop);
              outLast <= (nextTop == 5'd0);
              state   <= EMIT_DIGITS;
            end
          end
        end

        EMIT_SIGN: begin
          if (ser.out_ready) begin
            outChar <= digitChar(bcd, digitIdx);
            outLast <= (digitIdx == 5'd0);
            state   <= EMIT_DIGITS;
          end
        end

        EMIT_DIGITS: begin
          if (ser.out_ready) begin
            if (digitIdx == 5'd0) begin
              outValid <= 1'b0;
              outLast  <= 1'b0;
              inReady  <= 1'b1;
              busyReg  <= 1'b0;
              state    <= IDLE;
            end else begin
              digitIdx <= digitIdx - 5'd1;
              outChar  <= digitChar(bcd, digitIdx - 5'd1);
              outLast  <= (digitIdx == 5'd1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign ser.in_ready  = inReady;
  assign ser.out_char  = outChar;
  assign ser.out_valid = outValid;
  assign ser.out_last  = outLast;
  assign ser.busy      = busyReg;

endmodule
